nn_layer_scheduler: RTL and testbench

- Top-level sequencer for the inference pipeline.
- Runs NUM_LAYERS layer engines (conv, full_connect1, full_connect2, …) strictly in order. It pulses each engine's ena/iRst_n, waits for its done, then advances to the next.
- Owns the shared weight-ROM address bus and the shared 128-lane MultAdder operand buses. It muxes them from the single active layer, so only one engine touches the shared resources at a time.
- Reports overall busy/done/timeout status to the display/UART front end.

---
 rtl/nn_pkg.sv | 8 +
 rtl/nn_bus_mux.sv | 27 ++
 rtl/nn_layer_scheduler.sv | 86 ++++++++
 tb/tb_nn_layer_scheduler.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, default watchdog limit and scheduler state encoding
package nn_pkg;
  localparam int WORD_W      = 16;
  localparam int ADDR_W      = 11;
  localparam int LANES       = 128;
  localparam int TIMEOUT_DEF = 65535;
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_ADV, S_DONE, S_ERROR} state_t;
endpackage

// File: rtl/nn_bus_mux.sv
// nn_bus_mux: one-hot AND-OR mux of the shared ROM address and operand buses
module nn_bus_mux
  import nn_pkg::*;
#(
  parameter int N  = 3,
  parameter int AW = ADDR_W,
  parameter int OW = LANES * WORD_W
) (
  input  logic [N-1:0]    sel,
  input  logic [N*AW-1:0] addr_in,
  input  logic [N*OW-1:0] opr1_in,
  input  logic [N*OW-1:0] opr2_in,
  output logic [AW-1:0]   addr,
  output logic [OW-1:0]   opr1,
  output logic [OW-1:0]   opr2
);
  always_comb begin
    addr = '0;
    opr1 = '0;
    opr2 = '0;
    for (int k = 0; k < N; k++) begin
      addr |= {AW{sel[k]}} & addr_in[k*AW +: AW];
      opr1 |= {OW{sel[k]}} & opr1_in[k*OW +: OW];
      opr2 |= {OW{sel[k]}} & opr2_in[k*OW +: OW];
    end
  end
endmodule

// File: rtl/nn_layer_scheduler.sv
// nn_layer_scheduler: runs layer engines in order, owns the shared buses, watchdogs each layer
module nn_layer_scheduler
  import nn_pkg::*;
#(
  parameter int DATA_W         = WORD_W,
  parameter int NUM_LAYERS     = 3,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int IDX_W          = 2
) (
  input  logic                               clk,
  input  logic                               iRst,
  input  logic                               iStart,
  input  logic [NUM_LAYERS-1:0]              layer_done,
  input  logic [NUM_LAYERS*ADDR_W-1:0]       layer_addr,
  input  logic [NUM_LAYERS*LANES*DATA_W-1:0] layer_opr1,
  input  logic [NUM_LAYERS*LANES*DATA_W-1:0] layer_opr2,
  output logic [NUM_LAYERS-1:0]              layer_ena,
  output logic [NUM_LAYERS-1:0]              layer_rst_n,
  output logic [ADDR_W-1:0]                  addr_to_rom,
  output logic [LANES*DATA_W-1:0]            opr1_to_MultAdder,
  output logic [LANES*DATA_W-1:0]            opr2_to_MultAdder,
  output logic [IDX_W-1:0]                   oLayerIdx,
  output logic                               oBusy,
  output logic                               oDone,
  output logic                               oTimeout
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [WD_W-1:0]   wd, wd_n;
  logic              act, last, done_act;
  assign act      = state == S_INIT || state == S_RUN;
  assign last     = idx == IDX_W'(NUM_LAYERS - 1);
  assign done_act = |(layer_done & layer_ena);
  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      state <= S_IDLE;
      idx   <= '0;
      wd    <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      wd    <= wd_n;
    end
  end
  // done is checked before the watchdog so a coincident done still advances
  always_comb begin
    state_n = state;
    idx_n   = idx;
    wd_n    = wd;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        state_n = iStart ? S_INIT : state;
        idx_n   = iStart ? '0 : idx;
      end
      S_INIT: begin
        state_n = S_RUN;
        wd_n    = '0;
      end
      S_RUN: begin
        wd_n    = wd + 1'b1;
        state_n = done_act ? S_ADV : (wd == WD_W'(TIMEOUT_CYCLES - 1)) ? S_ERROR : S_RUN;
      end
      S_ADV: begin
        state_n = last ? S_DONE : S_INIT;
        idx_n   = last ? idx : idx + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end
  assign layer_ena   = act ? NUM_LAYERS'(1) << idx : '0;
  assign layer_rst_n = (state == S_INIT) ? ~(NUM_LAYERS'(1) << idx) : '1;
  assign oLayerIdx   = idx;
  assign oBusy       = act || state == S_ADV;
  assign oDone       = state == S_DONE;
  assign oTimeout    = state == S_ERROR;
  nn_bus_mux #(.N(NUM_LAYERS), .AW(ADDR_W), .OW(LANES * DATA_W)) u_mux (
    .sel     (layer_ena),
    .addr_in (layer_addr),
    .opr1_in (layer_opr1),
    .opr2_in (layer_opr2),
    .addr    (addr_to_rom),
    .opr1    (opr1_to_MultAdder),
    .opr2    (opr2_to_MultAdder)
  );
endmodule

// File: tb/tb_nn_layer_scheduler.sv
// tb_nn_layer_scheduler: open-loop schedule model drives engine done flags and predicts every output
module tb_nn_layer_scheduler;
  localparam int NL = 3, DW = 16, OW = 128 * DW, AW = 11, T = 64, NEVER = 1000;
  logic              clk = 1'b0, iRst, iStart;
  logic [NL-1:0]     layer_done, layer_ena, layer_rst_n;
  logic [NL*AW-1:0]  layer_addr;
  logic [NL*OW-1:0]  layer_opr1, layer_opr2;
  logic [AW-1:0]     addr_to_rom;
  logic [OW-1:0]     opr1_to_MultAdder, opr2_to_MultAdder;
  logic [1:0]        oLayerIdx;
  logic              oBusy, oDone, oTimeout;
  int checks = 0, errors = 0;
  typedef struct {
    logic [NL-1:0] ena, rstn, act, drv;
    logic [1:0]    idx;
    logic          busy, dn, to, ci;
  } exp_t;
  exp_t sched[$];

  nn_layer_scheduler #(.DATA_W(DW), .NUM_LAYERS(NL), .TIMEOUT_CYCLES(T), .IDX_W(2)) dut (
    .clk(clk), .iRst(iRst), .iStart(iStart), .layer_done(layer_done),
    .layer_addr(layer_addr), .layer_opr1(layer_opr1), .layer_opr2(layer_opr2),
    .layer_ena(layer_ena), .layer_rst_n(layer_rst_n), .addr_to_rom(addr_to_rom),
    .opr1_to_MultAdder(opr1_to_MultAdder), .opr2_to_MultAdder(opr2_to_MultAdder),
    .oLayerIdx(oLayerIdx), .oBusy(oBusy), .oDone(oDone), .oTimeout(oTimeout)
  );

  always #5 clk = ~clk;

  // Per-cycle expectation list; d = RUN cycle (0-based) on which done rises, >= T means never
  task automatic build(input int d0, input int d1, input int d2);
    int d[NL];
    int runs;
    exp_t e;
    d = '{d0, d1, d2};
    sched.delete();
    for (int k = 0; k < NL; k++) begin
      e.ena = NL'(1) << k; e.rstn = ~e.ena; e.act = e.ena; e.drv = '0;
      e.idx = 2'(k); e.busy = 1'b1; e.dn = 1'b0; e.to = 1'b0; e.ci = 1'b1;
      sched.push_back(e);
      e.rstn = '1;
      runs = d[k] < T ? d[k] + 1 : T;
      for (int j = 0; j < runs; j++) begin
        e.drv = (j == d[k]) ? e.ena : '0;
        sched.push_back(e);
      end
      if (d[k] >= T) begin
        e.ena = '0; e.act = '0; e.drv = '0; e.busy = 1'b0; e.to = 1'b1;
        sched.push_back(e);
        return;
      end
      e.ena = '0; e.drv = e.act;
      sched.push_back(e);
    end
    e.ena = '0; e.act = '0; e.drv = '0; e.busy = 1'b0; e.dn = 1'b1; e.ci = 1'b0;
    sched.push_back(e);
  endtask

  task automatic drive(input logic [NL-1:0] drv, input logic [NL-1:0] act, input logic st);
    for (int k = 0; k < NL; k++) layer_addr[k*AW +: AW] = AW'($urandom);
    for (int i = 0; i < NL * OW / 32; i++) begin
      layer_opr1[i*32 +: 32] = $urandom;
      layer_opr2[i*32 +: 32] = $urandom;
    end
    layer_done = drv | (NL'($urandom) & ~act);
    iStart = st;
  endtask

  task automatic play(input int d0, input int d1, input int d2, input int n);
    logic [AW-1:0] ea;
    logic [OW-1:0] e1, e2;
    exp_t e;
    int m;
    build(d0, d1, d2);
    m = (n < sched.size()) ? n : sched.size();
    @(negedge clk);
    drive('0, '0, 1'b1);
    for (int i = 0; i < m; i++) begin
      e = sched[i];
      @(negedge clk);
      drive(e.drv, e.act, e.busy ? 1'($urandom_range(0, 1)) : 1'b0);
      #1;
      ea = '0; e1 = '0; e2 = '0;
      for (int k = 0; k < NL; k++)
        if (e.ena[k]) begin
          ea = layer_addr[k*AW +: AW];
          e1 = layer_opr1[k*OW +: OW];
          e2 = layer_opr2[k*OW +: OW];
        end
      checks++; if (layer_ena !== e.ena) begin errors++; $display("FAIL ena cyc %0d got %b exp %b", i, layer_ena, e.ena); end
      checks++; if (layer_rst_n !== e.rstn) begin errors++; $display("FAIL rst_n cyc %0d got %b exp %b", i, layer_rst_n, e.rstn); end
      checks++; if (oBusy !== e.busy) begin errors++; $display("FAIL busy cyc %0d got %b exp %b", i, oBusy, e.busy); end
      checks++; if (oDone !== e.dn) begin errors++; $display("FAIL done cyc %0d got %b exp %b", i, oDone, e.dn); end
      checks++; if (oTimeout !== e.to) begin errors++; $display("FAIL timeout cyc %0d got %b exp %b", i, oTimeout, e.to); end
      if (e.ci) begin
        checks++; if (oLayerIdx !== e.idx) begin errors++; $display("FAIL idx cyc %0d got %0d exp %0d", i, oLayerIdx, e.idx); end
      end
      checks++; if (addr_to_rom !== ea) begin errors++; $display("FAIL addr cyc %0d got %h exp %h", i, addr_to_rom, ea); end
      checks++; if (opr1_to_MultAdder !== e1) begin errors++; $display("FAIL opr1 cyc %0d got %h exp %h", i, opr1_to_MultAdder[63:0], e1[63:0]); end
      checks++; if (opr2_to_MultAdder !== e2) begin errors++; $display("FAIL opr2 cyc %0d got %h exp %h", i, opr2_to_MultAdder[63:0], e2[63:0]); end
    end
    iStart = 1'b0;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iStart = 1'b0; layer_done = '0; layer_addr = '1; layer_opr1 = '1; layer_opr2 = '1;
    #2;
    checks++; if (layer_ena !== '0) begin errors++; $display("FAIL rst ena got %b exp 000", layer_ena); end
    checks++; if (layer_rst_n !== '1) begin errors++; $display("FAIL rst rst_n got %b exp 111", layer_rst_n); end
    checks++; if ({oBusy, oDone, oTimeout} !== 3'b000) begin errors++; $display("FAIL rst flags got %b exp 000", {oBusy, oDone, oTimeout}); end
    checks++; if (oLayerIdx !== 2'd0) begin errors++; $display("FAIL rst idx got %0d exp 0", oLayerIdx); end
    checks++; if (addr_to_rom !== '0) begin errors++; $display("FAIL rst addr got %h exp 0", addr_to_rom); end
    repeat (2) @(negedge clk);
    iRst = 1'b0;
  endtask

  task automatic test_normal();    play(19, 39, 9, NEVER);        endtask
  task automatic test_timeout();   play(5, NEVER, 7, NEVER); play(10, 3, 2, NEVER); endtask
  task automatic test_race();      play(T - 1, 3, 4, NEVER);      endtask
  task automatic test_ignored();   play(45, 2, 0, NEVER);         endtask

  task automatic test_async_reset();
    play(5, NEVER, 0, 14);
    @(posedge clk);
    #3 iRst = 1'b1;
    #1;
    checks++; if (layer_ena !== '0) begin errors++; $display("FAIL arst ena got %b exp 000", layer_ena); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL arst busy got %b exp 0", oBusy); end
    checks++; if (oLayerIdx !== 2'd0) begin errors++; $display("FAIL arst idx got %0d exp 0", oLayerIdx); end
    checks++; if (addr_to_rom !== '0) begin errors++; $display("FAIL arst addr got %h exp 0", addr_to_rom); end
    @(negedge clk);
    iRst = 1'b0;
    play(4, 8, 1, NEVER);
  endtask

  task automatic test_random();
    repeat (4) play($urandom_range(0, T - 1), $urandom_range(0, T - 1), $urandom_range(0, T - 1), NEVER);
    repeat (3) play($urandom_range(0, T + 8), $urandom_range(0, T + 8), $urandom_range(0, T + 8), NEVER);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_race();
    test_ignored();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
